// File: rtl/dwconv_pkg.sv
// Shared state encoding, default widths and arithmetic helpers for the depthwise conv engine.
// Latency: none (declarations only). Backpressure: none.
// Build option DWCONV_SAT_EN: sat_trunc clamps to the signed output range instead of wrapping.
package dwconv_pkg;

    typedef enum logic [2:0] {IDLE, RUN, PADCOL, PADROW, DRAIN} state_t;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_SUM_W    = 21;
    localparam int DEF_FRAC_W   = 8;
    localparam int DEF_CHANNELS = 256;
    localparam int DEF_K_SIZE   = 3;
    localparam int DEF_IMG_W    = 16;
    localparam int DEF_IMG_H    = 16;

    // Full-precision accumulator: product width plus growth for K*K terms plus the bias term.
    function automatic int acc_w(input int data_w, input int k_size);
        return 2 * data_w + $clog2(k_size * k_size) + 1;
    endfunction

    // Reduce a sign-extended value to sum_w bits: clamp when saturation is built in, else wrap.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] v, input int sum_w);
`ifdef DWCONV_SAT_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (sum_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (sum_w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - sum_w)) >>> (64 - sum_w);
`endif
    endfunction

endpackage

// File: rtl/dwconv_mac.sv
// K*K signed multiply-accumulate with bias, floor shift and sat/wrap to the output width.
// Latency: 1 cycle (single output register).
// Backpressure: output register loads only when adv is high; it holds otherwise.
module dwconv_mac
    import dwconv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SUM_W  = DEF_SUM_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int K_SIZE = DEF_K_SIZE
)(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              adv,
    input  logic                              win_vld,
    input  logic                              win_last,
    input  logic [K_SIZE*K_SIZE*DATA_W-1:0]   win,
    input  logic [K_SIZE*K_SIZE*DATA_W-1:0]   wts,
    input  logic [DATA_W-1:0]                 bias,
    output logic                              res_vld,
    output logic [SUM_W-1:0]                  res_dat,
    output logic                              res_last
);
    localparam int NT    = K_SIZE * K_SIZE;
    localparam int PW    = 2 * DATA_W;
    localparam int ACC_W = acc_w(DATA_W, K_SIZE);

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shifted;

    // Adder tree over all taps, bias pre-scaled so the final shift keeps it at unit weight.
    always_comb begin
        prod = '0;
        acc  = ACC_W'($signed(bias)) <<< FRAC_W;
        for (int t = 0; t < NT; t++) begin
            prod = PW'($signed(win[t*DATA_W +: DATA_W])) * PW'($signed(wts[t*DATA_W +: DATA_W]));
            acc  = acc + ACC_W'(prod);
        end
        shifted = acc >>> FRAC_W;
    end

    // Output register; data and last freeze while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_vld  <= 1'b0;
            res_dat  <= '0;
            res_last <= 1'b0;
        end else if (adv) begin
            res_vld  <= win_vld;
            res_last <= win_vld && win_last;
            if (win_vld) begin
                res_dat <= SUM_W'(sat_trunc(64'(shifted), SUM_W));
            end
        end
    end

endmodule

// File: rtl/dwconv_stream_engine.sv
// Streaming KxK depthwise conv over a channel-interleaved raster frame with internal zero padding (DWCONV_SAT_EN selects clamping).
// Latency: 2 unstalled cycles from the completing beat to out_valid.
// Backpressure: every stage and the zero-beat generator freeze while out_valid && !out_ready; in_ready drops then.
module dwconv_stream_engine
    import dwconv_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SUM_W    = DEF_SUM_W,
    parameter int FRAC_W   = DEF_FRAC_W,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int K_SIZE   = DEF_K_SIZE,
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H
)(
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           w_load_valid,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] w_load_ch,
    input  logic [K_SIZE*K_SIZE*DATA_W-1:0]                w_load_weight,
    input  logic [DATA_W-1:0]                              w_load_bias,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [DATA_W-1:0]                              in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [SUM_W-1:0]                               out_data,
    output logic                                           out_last,
    output logic                                           busy
);
    localparam int P     = (K_SIZE - 1) / 2;
    localparam int NT    = K_SIZE * K_SIZE;
    localparam int VW    = K_SIZE * DATA_W;
    localparam int LB_D  = (IMG_W + P) * CHANNELS;
    localparam int SR_D  = (K_SIZE - 1) * CHANNELS;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int COL_W = $clog2(IMG_W + P);
    localparam int ROW_W = $clog2(IMG_H + P);
    localparam int ADR_W = $clog2(LB_D);

    localparam logic [CH_W-1:0]  CH_LAST       = CH_W'(CHANNELS - 1);
    localparam logic [COL_W-1:0] COL_REAL_LAST = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W + P - 1);
    localparam logic [COL_W-1:0] COL_P         = COL_W'(P);
    localparam logic [ROW_W-1:0] ROW_REAL_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H + P - 1);
    localparam logic [ROW_W-1:0] ROW_P         = ROW_W'(P);
    localparam logic [ADR_W-1:0] ADR_LAST      = ADR_W'(LB_D - 1);

    state_t state, state_nx;

    logic [CH_W-1:0]  ch_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [ADR_W-1:0] lb_addr;

    // Weight store is left unreset; line buffers and column history clear on reset so padding reads zero.
    logic [NT*DATA_W-1:0]         wt_mem   [CHANNELS];
    logic [DATA_W-1:0]            bias_mem [CHANNELS];
    logic [(K_SIZE-1)*DATA_W-1:0] lb_mem   [LB_D];
    logic [VW-1:0]                col_sr   [SR_D];

    logic              adv, feed_st, pad_st, take, beat, ch_end, col_end, emit, last;
    logic [DATA_W-1:0] x;
    logic [VW-1:0]     vec;
    logic [VW-1:0]     cols [K_SIZE];
    logic [NT*DATA_W-1:0] win;

    logic                 s1_vld, s1_last;
    logic [NT*DATA_W-1:0] s1_win, s1_wts;
    logic [DATA_W-1:0]    s1_bias;

    // A beat is either an accepted input sample or an internally generated padding zero.
    assign adv      = !out_valid || out_ready;
    assign feed_st  = (state == IDLE) || (state == RUN);
    assign pad_st   = (state == PADCOL) || (state == PADROW);
    assign in_ready = adv && feed_st;
    assign take     = in_ready && in_valid;
    assign beat     = take || (pad_st && adv);
    assign x        = take ? in_data : '0;
    assign vec      = {lb_mem[lb_addr], x};
    assign ch_end   = (ch_cnt == CH_LAST);
    assign col_end  = (col_cnt == COL_LAST);
    assign emit     = (row_cnt >= ROW_P) && (col_cnt >= COL_P);
    assign last     = ch_end && col_end && (row_cnt == ROW_LAST);
    assign busy     = (state != IDLE);

    // Window assembly: column j back in time for this channel, element i rows back; tap t = ky*K+kx.
    always_comb begin
        cols[0] = vec;
        for (int j = 1; j < K_SIZE; j++) begin
            cols[j] = col_sr[j*CHANNELS-1];
        end
        win = '0;
        for (int ky = 0; ky < K_SIZE; ky++) begin
            for (int kx = 0; kx < K_SIZE; kx++) begin
                win[(ky*K_SIZE+kx)*DATA_W +: DATA_W] = cols[K_SIZE-1-kx][(K_SIZE-1-ky)*DATA_W +: DATA_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: real columns, then pad columns each row, then pad rows, then wait for the pipe to empty.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = RUN;
            RUN:     if (take && ch_end && (col_cnt == COL_REAL_LAST)) state_nx = PADCOL;
            PADCOL:  if (beat && ch_end && col_end)
                         state_nx = (row_cnt == ROW_REAL_LAST) ? PADROW : RUN;
            PADROW:  if (beat && last) state_nx = DRAIN;
            DRAIN:   if (!s1_vld && !out_valid) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Position counters, line buffers and per-channel column history advance once per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
            lb_addr <= '0;
            for (int i = 0; i < LB_D; i++) lb_mem[i] <= '0;
            for (int i = 0; i < SR_D; i++) col_sr[i] <= '0;
        end else if (beat) begin
            lb_mem[lb_addr] <= vec[(K_SIZE-1)*DATA_W-1:0];
            col_sr[0]       <= vec;
            for (int i = 1; i < SR_D; i++) col_sr[i] <= col_sr[i-1];
            lb_addr <= (lb_addr == ADR_LAST) ? '0 : lb_addr + 1'b1;
            ch_cnt  <= ch_end ? '0 : ch_cnt + 1'b1;
            if (ch_end) begin
                col_cnt <= col_end ? '0 : col_cnt + 1'b1;
                if (col_end) row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
            end
        end
    end

    // Weight/bias writes are accepted only between frames so a running frame keeps consistent weights.
    always_ff @(posedge clk) begin
        if (w_load_valid && (state == IDLE)) begin
            wt_mem[w_load_ch]   <= w_load_weight;
            bias_mem[w_load_ch] <= w_load_bias;
        end
    end

    // Stage 1: capture the completed window with its channel's weights when it maps to a real output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
            s1_win  <= '0;
            s1_wts  <= '0;
            s1_bias <= '0;
        end else if (adv) begin
            s1_vld <= beat && emit;
            if (beat && emit) begin
                s1_win  <= win;
                s1_wts  <= wt_mem[ch_cnt];
                s1_bias <= bias_mem[ch_cnt];
                s1_last <= last;
            end
        end
    end

    dwconv_mac #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .FRAC_W (FRAC_W),
        .K_SIZE (K_SIZE)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .adv      (adv),
        .win_vld  (s1_vld),
        .win_last (s1_last),
        .win      (s1_win),
        .wts      (s1_wts),
        .bias     (s1_bias),
        .res_vld  (out_valid),
        .res_dat  (out_data),
        .res_last (out_last)
    );

endmodule

// File: tb/tb_dwconv_stream_engine.sv
// Directed bench for dwconv_stream_engine on a 4x4x2 frame with a 3x3 kernel.
// Latency: n/a. Backpressure: exercised through an out_ready pattern.
// Expected values are hand-derived per output position (corner/edge/interior tap counts).
module tb_dwconv_stream_engine;
    localparam int DATA_W   = 16;
    localparam int SUM_W    = 21;
    localparam int FRAC_W   = 0;
    localparam int CHANNELS = 2;
    localparam int K_SIZE   = 3;
    localparam int IMG_W    = 4;
    localparam int IMG_H    = 4;
    localparam int NB       = IMG_W * IMG_H * CHANNELS;
    localparam int WW       = K_SIZE * K_SIZE * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              w_load_valid;
    logic [0:0]        w_load_ch;
    logic [WW-1:0]     w_load_weight;
    logic [DATA_W-1:0] w_load_bias;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SUM_W-1:0]  out_data;
    logic              out_last;
    logic              busy;

    int n_cmp;
    int n_bad;
    logic [SUM_W-1:0] got_dat [$];
    logic             got_last[$];

    dwconv_stream_engine #(
        .DATA_W   (DATA_W),
        .SUM_W    (SUM_W),
        .FRAC_W   (FRAC_W),
        .CHANNELS (CHANNELS),
        .K_SIZE   (K_SIZE),
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .w_load_valid  (w_load_valid),
        .w_load_ch     (w_load_ch),
        .w_load_weight (w_load_weight),
        .w_load_bias   (w_load_bias),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // kind 0: centre tap 1, bias 0; kind 1: all taps 1, bias 5; kind 2: all taps 0x7FFF, bias 0
    task automatic set_wv(input int kind, output logic [WW-1:0] wv, output logic [DATA_W-1:0] bv);
        wv = '0;
        bv = '0;
        for (int t = 0; t < K_SIZE*K_SIZE; t++) begin
            if (kind == 0)      wv[t*DATA_W +: DATA_W] = (t == 4) ? 16'd1 : 16'd0;
            else if (kind == 1) wv[t*DATA_W +: DATA_W] = 16'd1;
            else                wv[t*DATA_W +: DATA_W] = 16'h7FFF;
        end
        if (kind == 1) bv = 16'd5;
    endtask

    task automatic load_weights(input int kind);
        logic [WW-1:0]     wv;
        logic [DATA_W-1:0] bv;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            @(negedge clk);
            set_wv(kind, wv, bv);
            w_load_valid  = 1'b1;
            w_load_ch     = 1'(ch);
            w_load_weight = wv;
            w_load_bias   = bv;
        end
        @(negedge clk);
        w_load_valid = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] in_val(input int kind, input int idx);
        case (kind)
            0:       return 16'(idx + 1);
            1:       return 16'd1;
            default: return 16'h7FFF;
        endcase
    endfunction

    // Output beat j is pixel j/2, channel j%2; n = number of kernel taps landing inside the frame.
    function automatic logic [SUM_W-1:0] exp_val(input int kind, input int j);
        int p;
        int r;
        int c;
        int n;
        p = j / CHANNELS;
        r = p / IMG_W;
        c = p % IMG_W;
        n = ((r == 0 || r == IMG_H-1) ? 2 : 3) * ((c == 0 || c == IMG_W-1) ? 2 : 3);
        case (kind)
            0:       return 21'(j + 1);
            1:       return 21'(n + 5);
            default: begin
`ifdef DWCONV_SAT_EN
                return 21'h0FFFFF;
`else
                return (n == 4) ? 21'h1C0004 : (n == 6) ? 21'h1A0006 : 21'h170009;
`endif
            end
        endcase
    endfunction

    // Stream one full frame, collect outputs, then compare against the expectation table.
    task automatic run_frame(input string tag, input int kind, input int exp_kind, input bit stall, input int wl_cyc);
        int idx;
        int cyc;
        logic [WW-1:0]     wv;
        logic [DATA_W-1:0] bv;
        idx = 0;
        cyc = 0;
        got_dat.delete();
        got_last.delete();
        while (cyc < 800 && !(got_dat.size() == NB && idx == NB && !busy)) begin
            @(negedge clk);
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            in_valid  = (idx < NB);
            in_data   = in_valid ? in_val(kind, idx) : '0;
            if (cyc == wl_cyc || cyc == wl_cyc + 1) begin
                set_wv(1, wv, bv);
                w_load_valid  = 1'b1;
                w_load_ch     = 1'(cyc - wl_cyc);
                w_load_weight = wv;
                w_load_bias   = bv;
            end else begin
                w_load_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                got_dat.push_back(out_data);
                got_last.push_back(out_last);
            end
            cyc++;
        end
        @(negedge clk);
        in_valid     = 1'b0;
        w_load_valid = 1'b0;
        out_ready    = 1'b1;
        check($sformatf("%s beats", tag), 32'(got_dat.size()), 32'(NB));
        check($sformatf("%s idle", tag), 32'(busy), 32'd0);
        for (int j = 0; j < got_dat.size() && j < NB; j++) begin
            check($sformatf("%s dat[%0d]", tag, j), 32'(got_dat[j]), 32'(exp_val(exp_kind, j)));
            check($sformatf("%s last[%0d]", tag, j), 32'(got_last[j]), 32'(j == NB - 1));
        end
    endtask

    task automatic feed_partial(input int n);
        int fed;
        int cyc;
        fed = 0;
        cyc = 0;
        out_ready = 1'b1;
        while (fed < n && cyc < 200) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = in_val(0, fed);
            #1;
            if (in_ready) fed++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("partial fed", 32'(fed), 32'(n));
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        w_load_valid = 1'b0;
        w_load_ch = '0;
        w_load_weight = '0;
        w_load_bias = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst out_last", 32'(out_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        // Identity kernel passes the frame through unchanged
        load_weights(0);
        run_frame("ident", 0, 0, 1'b0, -10);

        // Same frame under out_ready 1,0,0,1 backpressure
        run_frame("stall", 0, 0, 1'b1, -10);

        // All-ones kernel with bias 5 on an all-ones frame
        load_weights(1);
        run_frame("ones", 1, 1, 1'b0, -10);

        // Full-scale taps and inputs: saturate or wrap
        load_weights(2);
        run_frame("big", 2, 2, 1'b0, -10);

        // Abandon a frame in row 2 via reset, then a clean frame
        load_weights(0);
        feed_partial(20);
        rst_n = 1'b0;
        #1;
        check("mid rst out_valid", 32'(out_valid), 32'd0);
        check("mid rst out_last", 32'(out_last), 32'd0);
        check("mid rst busy", 32'(busy), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("in rst out_valid[%0d]", i), 32'(out_valid), 32'd0);
        end
        rst_n = 1'b1;
        load_weights(0);
        run_frame("after rst", 0, 0, 1'b0, -10);

        // Loads during RUN are ignored; a load in IDLE takes effect next frame
        run_frame("wl in run", 0, 0, 1'b0, 10);
        load_weights(1);
        run_frame("wl in idle", 1, 1, 1'b0, -10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
